// File: rtl/lsu_mem_adapter_pkg.sv
// Shared definitions for the load/store adapter: RV32I funct3/opcode values,
// FSM state encoding and small decode helpers used by the adapter.
package lsu_mem_adapter_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   localparam logic [6:0] OPCODE_I_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_S_STORE = 7'b0100011;

   localparam logic [2:0] LSU_ST_IDLE   = 3'd0;
   localparam logic [2:0] LSU_ST_ISSUE0 = 3'd1;
   localparam logic [2:0] LSU_ST_DATA0  = 3'd2;
   localparam logic [2:0] LSU_ST_ISSUE1 = 3'd3;
   localparam logic [2:0] LSU_ST_DATA1  = 3'd4;
   localparam logic [2:0] LSU_ST_RESP   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = LSU_ST_IDLE,
      S_ISSUE0 = LSU_ST_ISSUE0,
      S_DATA0  = LSU_ST_DATA0,
      S_ISSUE1 = LSU_ST_ISSUE1,
      S_DATA1  = LSU_ST_DATA1,
      S_RESP   = LSU_ST_RESP
   } lsu_state_e;

   // Access size in bytes from funct3[1:0]; code 11 only occurs on illegal
   // funct3 values, which never reach the memory side.
   function automatic logic [2:0] size_bytes(input logic [1:0] code);
      case (code)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] code);
      return (({1'b0, off} + size_bytes(code)) > 3'd4);
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
      return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
             (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
   endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Combinational lane logic for the load/store adapter.
//   size_code   : funct3[1:0] (00 byte, 01 half, 10 word)
//   is_unsigned : funct3[2], selects zero- vs sign-extension of loads
//   off         : byte offset addr[1:0]
//   wdata       : right-aligned store data
//   lo / hi     : first / second memory word of a load (hi = 0 if not crossing)
//   lanemask    : 8-lane enable mask spanning the two words
//   wdata_lo/hi : lane-aligned store data for the first / second word
//   rdata_ext   : extracted and extended load result
module lsu_byte_align
   import lsu_mem_adapter_pkg::*;
(
   input  logic [1:0]  size_code,
   input  logic        is_unsigned,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [7:0]  lanemask,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   output logic [31:0] rdata_ext
);

   logic [3:0]  base_mask;
   logic [63:0] wd_shift;
   logic [31:0] rd_word;

   always_comb begin
      case (size_code)
         2'b00:   base_mask = 4'b0001;
         2'b01:   base_mask = 4'b0011;
         default: base_mask = 4'b1111;
      endcase
      lanemask = {4'b0000, base_mask} << off;

      wd_shift = {32'h0000_0000, wdata} << {off, 3'b000};
      wdata_lo = wd_shift[31:0];
      wdata_hi = wd_shift[63:32];

      rd_word = 32'({hi, lo} >> {off, 3'b000});
      case (size_code)
         2'b00:   rdata_ext = is_unsigned ? {24'h0, rd_word[7:0]}
                                          : {{24{rd_word[7]}}, rd_word[7:0]};
         2'b01:   rdata_ext = is_unsigned ? {16'h0, rd_word[15:0]}
                                          : {{16{rd_word[15]}}, rd_word[15:0]};
         default: rdata_ext = rd_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core memory stage and a word-addressed data
// memory. Accepts one request at a time, drives registered memory strobes,
// splits word-crossing accesses into two transactions and returns extended
// load data.
//   req_*  : core request (valid/ready handshake, fields captured on accept)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   mem_*  : registered memory strobe/address/lanes/data; mem_rdata is
//            valid the cycle after a read strobe
//
// state  | meaning
// IDLE   | ready for a new request
// ISSUE0 | first word access on the memory bus
// DATA0  | first word read data returning
// ISSUE1 | second word access (crossing only)
// DATA1  | second word read data returning
// RESP   | rsp_valid pulse
module lsu_mem_adapter
   import lsu_mem_adapter_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       lo_q, lo_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cross_q, cross_d;

   logic              req_cross, req_err;
   logic [ADDR_W-1:0] word_next;
   logic [1:0]        al_size;
   logic              al_uns;
   logic [1:0]        al_off;
   logic [31:0]       al_wdata, al_lo, al_hi;
   logic [7:0]        lanemask;
   logic [31:0]       wdata_lo, wdata_hi, rdata_ext;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign req_cross = crosses_word(req_addr[1:0], req_funct3[1:0]);
   assign req_err   = !funct3_legal(req_we, req_funct3) || (req_cross && !MISALIGN_EN);
   assign word_next = word_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   // In IDLE the lane logic looks at the live request so the first issue can
   // be registered on the accept edge; afterwards it uses the captured copy.
   // Returning read data is fed straight in so the response is registered on
   // the same edge the data arrives.
   always_comb begin
      al_size  = f3_q[1:0];
      al_uns   = f3_q[2];
      al_off   = off_q;
      al_wdata = wdata_q;
      al_lo    = lo_q;
      al_hi    = 32'h0;
      if (state_q == S_IDLE) begin
         al_size  = req_funct3[1:0];
         al_uns   = req_funct3[2];
         al_off   = req_addr[1:0];
         al_wdata = req_wdata;
      end
      if (state_q == S_DATA0) al_lo = mem_rdata;
      if (state_q == S_DATA1) al_hi = mem_rdata;
   end

   lsu_byte_align u_align (
      .size_code   (al_size),
      .is_unsigned (al_uns),
      .off         (al_off),
      .wdata       (al_wdata),
      .lo          (al_lo),
      .hi          (al_hi),
      .lanemask    (lanemask),
      .wdata_lo    (wdata_lo),
      .wdata_hi    (wdata_hi),
      .rdata_ext   (rdata_ext)
   );

   // Reads always fetch the whole word; the lane shift happens on return.
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      lo_d        = lo_q;
      we_d        = we_q;
      f3_d        = f3_q;
      off_d       = off_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      cross_d     = cross_q;

      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (req_valid && ready_q) begin
               ready_d = 1'b0;
               we_d    = req_we;
               f3_d    = req_funct3;
               off_d   = req_addr[1:0];
               word_d  = req_addr[ADDR_W+1:2];
               wdata_d = req_wdata;
               cross_d = req_cross;
               if (req_err) begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else begin
                  state_d    = S_ISSUE0;
                  mem_en_d   = 1'b1;
                  mem_we_d   = req_we;
                  mem_addr_d = req_addr[ADDR_W+1:2];
                  if (req_we) begin
                     mem_be_d    = lanemask[3:0];
                     mem_wdata_d = wdata_lo;
                  end else begin
                     mem_be_d = 4'hF;
                  end
               end
            end
         end
         S_ISSUE0: begin
            if (!we_q) begin
               state_d = S_DATA0;
            end else if (cross_q) begin
               state_d     = S_ISSUE1;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = word_next;
               mem_be_d    = lanemask[7:4];
               mem_wdata_d = wdata_hi;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end
         end
         S_DATA0: begin
            lo_d = mem_rdata;
            if (cross_q) begin
               state_d    = S_ISSUE1;
               mem_en_d   = 1'b1;
               mem_addr_d = word_next;
               mem_be_d   = 4'hF;
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = rdata_ext;
            end
         end
         S_ISSUE1: begin
            if (we_q) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
            end else begin
               state_d = S_DATA1;
            end
         end
         S_DATA1: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = rdata_ext;
         end
         S_RESP: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
         lo_q        <= 32'h0;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         word_q      <= '0;
         wdata_q     <= 32'h0;
         cross_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         lo_q        <= lo_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         cross_q     <= cross_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Bench for lsu_mem_adapter: directed cases plus randomized requests checked
// against a byte-level memory model.
module tb_lsu_mem_adapter;

   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic          req_valid0, req_ready0, req_we0, rsp_valid0, rsp_err0;
   logic [2:0]    req_funct3_0;
   logic [31:0]   req_addr0, req_wdata0, rsp_rdata0, mem_wdata0, mem_rdata0;
   logic          mem_en0, mem_we0;
   logic [3:0]    mem_be0;
   logic [AW-1:0] mem_addr0;

   logic          req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1;
   logic [2:0]    req_funct3_1;
   logic [31:0]   req_addr1, req_wdata1, rsp_rdata1, mem_wdata1, mem_rdata1;
   logic          mem_en1, mem_we1;
   logic [3:0]    mem_be1;
   logic [AW-1:0] mem_addr1;
   assign mem_rdata1 = 32'h0;

   lsu_mem_adapter #(.ADDR_W(AW), .MISALIGN_EN(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_funct3(req_funct3_0), .req_addr(req_addr0), .req_wdata(req_wdata0),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

   lsu_mem_adapter #(.ADDR_W(AW), .MISALIGN_EN(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
      .req_funct3(req_funct3_1), .req_addr(req_addr1), .req_wdata(req_wdata1),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

   // Data memory seen by dut0
   logic [31:0] mem_arr [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en0) begin
         if (mem_we0) begin
            for (int b = 0; b < 4; b++)
               if (mem_be0[b]) mem_arr[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
         end else begin
            mem_rdata0 <= mem_arr[mem_addr0];
         end
      end
   end

   // Bus monitors
   int en_cnt0 = 0, en_cnt1 = 0, rv_cnt0 = 0, rd_be_bad = 0;
   logic [AW-1:0] wl_addr [$];
   logic [3:0]    wl_be   [$];
   logic [31:0]   wl_data [$];
   always @(negedge clk) begin
      if (mem_en0) begin
         en_cnt0 <= en_cnt0 + 1;
         if (!mem_we0 && mem_be0 != 4'hF) rd_be_bad <= rd_be_bad + 1;
         if (mem_we0) begin
            wl_addr.push_back(mem_addr0);
            wl_be.push_back(mem_be0);
            wl_data.push_back(mem_wdata0);
         end
      end
      if (mem_en1) en_cnt1 <= en_cnt1 + 1;
      if (rsp_valid0) rv_cnt0 <= rv_cnt0 + 1;
   end

   // Reference model: byte-addressed memory, wrapping at 4*2^AW bytes
   localparam int MEM_BYTES = 4 << AW;
   logic [7:0] ref_mem [0:MEM_BYTES-1];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int m_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit m_legal(input bit we, input logic [2:0] f3);
      if (we) return f3 <= 3'd2;
      return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic bit m_cross(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) + m_size(f3)) > 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
      int sz = m_size(f3);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(a[11:0]) + i) % MEM_BYTES];
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
      return v;
   endfunction

   task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < m_size(f3); i++) ref_mem[(int'(a[11:0]) + i) % MEM_BYTES] = d[8*i +: 8];
   endtask

   task automatic do_req(input bit sel, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err,
                         output int lat, output int ens);
      int en_base;
      @(negedge clk);
      en_base = sel ? en_cnt1 : en_cnt0;
      chk("req_ready", 32'(sel ? req_ready1 : req_ready0), 32'd1);
      if (sel) begin
         req_valid1 = 1'b1; req_we1 = we; req_funct3_1 = f3; req_addr1 = addr; req_wdata1 = wd;
      end else begin
         req_valid0 = 1'b1; req_we0 = we; req_funct3_0 = f3; req_addr0 = addr; req_wdata0 = wd;
      end
      @(negedge clk);
      lat = 1;
      // Request fields change after accept; the adapter must use its copy.
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      req_we0 = 1'($urandom); req_funct3_0 = 3'($urandom); req_addr0 = $urandom; req_wdata0 = $urandom;
      req_we1 = 1'($urandom); req_funct3_1 = 3'($urandom); req_addr1 = $urandom; req_wdata1 = $urandom;
      while (!(sel ? rsp_valid1 : rsp_valid0) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd  = sel ? rsp_rdata1 : rsp_rdata0;
      err = sel ? rsp_err1 : rsp_err0;
      ens = (sel ? en_cnt1 : en_cnt0) - en_base;
      @(negedge clk);
      chk("rsp_pulse", 32'(sel ? rsp_valid1 : rsp_valid0), 32'd0);
   endtask

   task automatic run_chk(input string tag, input bit sel, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] e_rd, input bit e_err, input int e_lat, input int e_en);
      logic [31:0] rd;
      logic err;
      int lat, ens;
      do_req(sel, we, f3, addr, wd, rd, err, lat, ens);
      chk({tag, ".rdata"}, rd, e_rd);
      chk({tag, ".err"}, 32'(err), 32'(e_err));
      chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
      chk({tag, ".mem_en_count"}, 32'(ens), 32'(e_en));
   endtask

   // Expected outcome of a dut0 request derived from the model, then applied.
   task automatic model_req(input string tag, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
      bit err = !m_legal(we, f3);
      bit cr = !err && m_cross(f3, addr);
      int lat = err ? 1 : we ? (cr ? 3 : 2) : (cr ? 5 : 3);
      int en = err ? 0 : (cr ? 2 : 1);
      logic [31:0] e_rd = (err || we) ? 32'h0 : m_load(f3, addr);
      run_chk(tag, 1'b0, we, f3, addr, wd, e_rd, err, lat, en);
      if (!err && we) m_store(f3, addr, wd);
   endtask

   initial begin
      int wl_base, rv_base, be_base;
      logic [31:0] w;
      logic [31:0] a;
      logic [2:0] f3;
      bit we;
      int t;

      rst_n = 1'b0;
      req_valid0 = 0; req_we0 = 0; req_funct3_0 = 0; req_addr0 = 0; req_wdata0 = 0;
      req_valid1 = 0; req_we1 = 0; req_funct3_1 = 0; req_addr1 = 0; req_wdata1 = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         w = (i == 0) ? 32'hff04a1c0 : (i == 1) ? 32'h12345678 : $urandom;
         mem_arr[i] <= w;
         for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
      end

      #12;
      chk("rst.req_ready", 32'(req_ready0), 32'd1);
      chk("rst.rsp_valid", 32'(rsp_valid0), 32'd0);
      chk("rst.rsp_err", 32'(rsp_err0), 32'd0);
      chk("rst.rsp_rdata", rsp_rdata0, 32'h0);
      chk("rst.mem_en_we", {30'h0, mem_en0, mem_we0}, 32'h0);
      chk("rst.mem_be", 32'(mem_be0), 32'h0);
      chk("rst.mem_addr", 32'(mem_addr0), 32'h0);
      chk("rst.mem_wdata", mem_wdata0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases on preloaded words
      be_base = rd_be_bad;
      run_chk("lb1",  0, 0, 3'b000, 32'd1, 32'h0, 32'hFFFFFFA1, 0, 3, 1);
      run_chk("lbu1", 0, 0, 3'b100, 32'd1, 32'h0, 32'h000000A1, 0, 3, 1);
      run_chk("lh2",  0, 0, 3'b001, 32'd2, 32'h0, 32'hFFFFFF04, 0, 3, 1);
      run_chk("lhu2", 0, 0, 3'b101, 32'd2, 32'h0, 32'h0000FF04, 0, 3, 1);
      run_chk("lw0",  0, 0, 3'b010, 32'd0, 32'h0, 32'hff04a1c0, 0, 3, 1);
      run_chk("lw3",  0, 0, 3'b010, 32'd3, 32'h0, 32'h345678FF, 0, 5, 2);
      chk("read_be_all_lanes", 32'(rd_be_bad - be_base), 32'd0);

      wl_base = wl_addr.size();
      run_chk("sh3", 0, 1, 3'b001, 32'd3, 32'h0000BEEF, 32'h0, 0, 3, 2);
      m_store(3'b001, 32'd3, 32'h0000BEEF);
      chk("sh3.writes", 32'(wl_addr.size() - wl_base), 32'd2);
      if (wl_addr.size() - wl_base == 2) begin
         chk("sh3.w0.addr", 32'(wl_addr[wl_base]), 32'd0);
         chk("sh3.w0.be", 32'(wl_be[wl_base]), 32'b1000);
         chk("sh3.w0.data", wl_data[wl_base], 32'hEF000000);
         chk("sh3.w1.addr", 32'(wl_addr[wl_base+1]), 32'd1);
         chk("sh3.w1.be", 32'(wl_be[wl_base+1]), 32'b0001);
         chk("sh3.w1.data", wl_data[wl_base+1], 32'h000000BE);
      end
      run_chk("lw0_after", 0, 0, 3'b010, 32'd0, 32'h0, 32'hEF04a1c0, 0, 3, 1);
      run_chk("lw4_after", 0, 0, 3'b010, 32'd4, 32'h0, 32'h123456BE, 0, 3, 1);

      run_chk("ld_f3_011", 0, 0, 3'b011, 32'd0, 32'h0, 32'h0, 1, 1, 0);
      run_chk("st_f3_100", 0, 1, 3'b100, 32'd0, 32'h1234, 32'h0, 1, 1, 0);

      // Misalignment disabled
      run_chk("noma.lh3", 1, 0, 3'b001, 32'd3, 32'h0, 32'h0, 1, 1, 0);
      run_chk("noma.lw2", 1, 0, 3'b010, 32'd2, 32'h0, 32'h0, 1, 1, 0);
      run_chk("noma.lh1", 1, 0, 3'b001, 32'd1, 32'h0, 32'h0, 0, 3, 1);

      // Reset during the second issue of a crossing load
      @(negedge clk);
      req_valid0 = 1'b1; req_we0 = 1'b0; req_funct3_0 = 3'b010; req_addr0 = 32'd3;
      @(negedge clk);
      req_valid0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid.issue1_en", 32'(mem_en0), 32'd1);
      rv_base = rv_cnt0;
      rst_n = 1'b0;
      #1;
      chk("rstmid.mem_en", 32'(mem_en0), 32'd0);
      chk("rstmid.rsp_valid", 32'(rsp_valid0), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid.no_rsp", 32'(rv_cnt0 - rv_base), 32'd0);
      chk("rstmid.ready", 32'(req_ready0), 32'd1);
      run_chk("rstmid.lb1", 0, 0, 3'b000, 32'd1, 32'h0, 32'hFFFFFFA1, 0, 3, 1);

      // Randomized requests, including wrap from the last word to word 0
      for (int n = 0; n < 80; n++) begin
         we = 1'($urandom);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else begin
            t = $urandom_range(0, 4);
            f3 = 3'((t > 2) ? t + 1 : t);
         end
         a = $urandom;
         a[11:0] = $urandom_range(0, 1) ? 12'($urandom_range(0, 31))
                                        : 12'($urandom_range(MEM_BYTES - 32, MEM_BYTES - 1));
         model_req($sformatf("rnd%0d", n), we, f3, a, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
